// File: rtl/offset_calibrator.sv
// Offset calibrator: averages grounded-input ADC samples and produces the signed
// offset that recentres the front-end adder output at midscale.
module offset_calibrator #(
  parameter int LOG2_N = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] smpl_i,
  input  logic       smpl_vld_i,
  output logic [7:0] off_o,
  output logic       off_vld_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_CALC   = 2'd3
  } state_t;

  localparam int AW = 8 + LOG2_N;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [LOG2_N:0] SMPL_LAST   = {1'b0, {LOG2_N{1'b1}}};
  localparam logic [LOG2_N:0] SMPL_ONE    = {{LOG2_N{1'b0}}, 1'b1};

  state_t          state_q;
  logic [3:0]      settle_cnt_q;
  logic [LOG2_N:0] smpl_cnt_q;
  logic [AW-1:0]   acc_q;
  logic [7:0]      off_q;
  logic            off_vld_q;
  logic            done_q;

  logic [7:0]        avg_d;
  logic signed [9:0] diff_d;
  logic [7:0]        off_d;

  // Only an all-zero average pushes the difference to +128, which is clamped.
  always_comb begin
    avg_d  = acc_q[AW-1:LOG2_N];
    diff_d = 10'sd128 - $signed({2'b00, avg_d});
    off_d  = (diff_d > 10'sd127) ? 8'h7F : diff_d[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      smpl_cnt_q   <= '0;
      acc_q        <= '0;
      off_q        <= 8'h00;
      off_vld_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_q        <= '0;
            settle_cnt_q <= '0;
            smpl_cnt_q   <= '0;
            state_q      <= (SETTLE > 0) ? S_SETTLE : S_ACCUM;
          end
        end
        S_SETTLE: begin
          if (smpl_vld_i) begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
            if (settle_cnt_q == SETTLE_LAST) state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (smpl_vld_i) begin
            acc_q      <= acc_q + {{LOG2_N{1'b0}}, smpl_i};
            smpl_cnt_q <= smpl_cnt_q + SMPL_ONE;
            if (smpl_cnt_q == SMPL_LAST) state_q <= S_CALC;
          end
        end
        S_CALC: begin
          // off only ever changes here, so downstream never sees a partial value.
          off_q     <= off_d;
          off_vld_q <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign off_o     = off_q;
  assign off_vld_o = off_vld_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule

// File: doc/offset_calibrator.md
Name: offset_calibrator

Overview:
- Computes the signed 8-bit offset word consumed by the DSO front-end saturating offset adder, i.e. it is the writer of the `off` operand.
- During calibration the channel input is grounded. The block averages 2^LOG2_N raw unsigned ADC samples after discarding SETTLE warm-up samples.
- It then produces off = 0x80 - avg, saturated to signed 8-bit, so that raw+off lands at midscale.
- The result is held in a register until the next calibration completes.

Parameters:
LOG2_N, 4, log2 of number of averaged samples (1..8)
SETTLE, 2, number of valid samples discarded after start before accumulation (0..15)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin calibration
smpl  input  8  raw unsigned ADC sample
smpl_vld  input  1  smpl is valid this cycle
off  output  8  signed two's-complement offset to adder (registered)
off_vld  output  1  high once a calibration has completed since reset
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when off updated

Behaviour:
- One clock; reset is synchronous and active-high. On rst: state=IDLE, off=0x00, off_vld=0, busy=0, done=0, accumulator=0, counters=0.
- States: IDLE, SETTLE, ACCUM, CALC.
- IDLE:
  - start=1 -> SETTLE if SETTLE>0, else ACCUM.
  - Clears the accumulator and counters on that transition.
  - start while not IDLE is ignored; no restart, no queueing.
- SETTLE: counts smpl_vld cycles only; smpl is discarded. After the SETTLE-th valid sample -> ACCUM.
- ACCUM:
  - On each smpl_vld, acc += smpl (zero-extended). acc width = 8+LOG2_N, so it never overflows.
  - Cycles with smpl_vld=0 are stalls: no change, no timeout.
  - After the 2^LOG2_N-th valid sample is added -> CALC.
- CALC, one cycle:
  - avg = acc >> LOG2_N (truncation, 0..255).
  - d = 128 - avg computed in 10-bit signed. d > 127 -> off=0x7F; else off=d[7:0]. d cannot go below -127.
  - Set off_vld=1 and pulse done=1 in this cycle's registered outputs, i.e. visible the cycle after the CALC state cycle. Then -> IDLE.
- Latency: done asserts 1 clock after the final counted valid sample is accepted in ACCUM, plus 1 for CALC registration. Total = SETTLE + 2^LOG2_N valid samples + 2 clk.
- off holds its previous value for the whole calibration and changes only in the same cycle done is high. The adder never sees a partial value.
- busy is combinational from state (state != IDLE) and is low the cycle done is high.
- start in the same cycle done is high is accepted (state is IDLE) and begins a new calibration.
- smpl_vld in IDLE is ignored.
- rst mid-calibration: abort immediately to reset values. off returns to 0x00 and off_vld to 0; a prior result is lost.
- Counter widths: settle counter 4 bits, sample counter LOG2_N+1 bits; no wrap within one calibration.

Test Plan:
- Defaults. Pulse start, feed 2 samples of 0xFF then 16 samples of 0x70, smpl_vld continuous -> settle samples ignored; done pulse 20 clk after start; off=0x10, off_vld=1, busy low.
- 16 samples of 0x80 -> off=0x00. 16 samples of 0x00 -> d=128 clamps, off=0x7F. 16 samples of 0xFF -> off=0x81 (-127).
- 16 samples alternating 0x7F/0x80 (sum 2040, avg 127) -> off=0x01. smpl_vld deasserted every other cycle -> same result, done delayed by the stall count; off holds the old value until done.
- start re-pulsed during ACCUM -> ignored, result unchanged. start in the done cycle -> new calibration begins, busy high the next cycle.
- Complete one calibration (off=0x10), start a second, assert rst after 5 samples -> off=0x00, off_vld=0, busy=0 the next cycle. A subsequent calibration runs normally.
- LOG2_N=1, SETTLE=0: samples 0x01, 0x02 -> avg=1 (truncation), off=0x7F.
